// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage plus IF/ID pipeline register.
// Keeps one instruction-memory request in flight at a time, parks a response
// in a one-entry skid buffer while decode cannot take it, and flushes and
// refetches on a redirect from execute.
// Optional build macro FETCH_PERF_COUNT_EN adds fetch_count/stall_count.
// A redirect that lands while a flushed response is still being drained keeps
// the unit in DRAIN so a second request is never issued with one in flight.
// A drained response that arrives while halted parks the unit in IDLE, so the
// refetch request is only raised once halted drops.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halted,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        decode_valid,
  output logic [31:0] decode_instr,
  output logic [31:0] decode_pc,
  output logic [4:0]  decode_opcode,
  output logic [4:0]  decode_reg1,
  output logic [4:0]  decode_reg2
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        dec_valid_q, dec_valid_d;
  logic [31:0] dec_instr_q, dec_instr_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  // Skid word is only meaningful in S_HOLD; its address is always pc_q.
  logic [31:0] skid_q, skid_d;

  logic        adv;
  logic        load;
  logic [31:0] pc_inc;
  logic [31:0] target;

  // Next-state, IF/ID and request logic; halted first, then redirect, then normal flow.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    skid_d      = skid_q;
    load        = 1'b0;
    adv         = !stall && !halted;
    pc_inc      = pc_q + 32'd4;
    target      = redirect_pc & ~32'd3;

    if (halted) begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            state_d    = S_WAIT;
            imem_req_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_IDLE;
        end
        default: ;
      endcase
    end else if (redirect_valid) begin
      pc_d        = target;
      dec_valid_d = 1'b0;
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_REQ:   state_d = imem_gnt ? S_DRAIN : S_REQ;
        S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (adv || !dec_valid_q) begin
              load        = 1'b1;
              dec_valid_d = 1'b1;
              dec_instr_d = imem_rdata;
              dec_pc_d    = pc_q;
              pc_d        = pc_inc;
              state_d     = S_REQ;
            end else begin
              skid_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (adv) begin
            load        = 1'b1;
            dec_valid_d = 1'b1;
            dec_instr_d = skid_q;
            dec_pc_d    = pc_q;
            pc_d        = pc_inc;
            state_d     = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
      if (adv && !load) dec_valid_d = 1'b0;
    end

    if (!halted) begin
      imem_req_d = (state_d == S_REQ);
      if (state_d == S_REQ) imem_addr_d = pc_d;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'd0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= 32'd0;
      dec_pc_q    <= 32'd0;
      skid_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      skid_q      <= skid_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = imem_addr_q;
  assign decode_valid  = dec_valid_q;
  assign decode_instr  = dec_instr_q;
  assign decode_pc     = dec_pc_q;
  assign decode_opcode = dec_instr_q[4:0];
  assign decode_reg1   = dec_instr_q[14:10];
  assign decode_reg2   = dec_instr_q[19:15];

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Counter increments: words loaded into IF/ID and cycles a valid instruction is stalled.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (load) fetch_count_d = fetch_count_q + 32'd1;
    if (dec_valid_q && stall && !halted) stall_count_d = stall_count_q + 32'd1;
  end

  // Performance counter registers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle-table, directed corner-case and randomized checks of fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        halted;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        decode_valid;
  logic [31:0] decode_instr;
  logic [31:0] decode_pc;
  logic [4:0]  decode_opcode;
  logic [4:0]  decode_reg1;
  logic [4:0]  decode_reg2;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .halted         (halted),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .decode_valid   (decode_valid),
    .decode_instr   (decode_instr),
    .decode_pc      (decode_pc),
    .decode_opcode  (decode_opcode),
    .decode_reg1    (decode_reg1),
    .decode_reg2    (decode_reg2)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_dv;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [13];

  // Memory contents seen by the randomized test: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic hl, input logic rdr, input logic [31:0] rpc,
                               input logic g, input logic rv, input logic [31:0] rd);
    stall          = st;
    halted         = hl;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 0, 32'd0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic checkDecode(input string name, input logic dv, input logic [31:0] pc, input logic [31:0] instr);
    logic [31:0] w;
    w = instr;
    checkOutput({name, "_dv"}, decode_valid, dv);
    checkOutput({name, "_pc"}, decode_pc, pc);
    checkOutput({name, "_instr"}, decode_instr, instr);
    checkOutput({name, "_opcode"}, decode_opcode, w[4:0]);
    checkOutput({name, "_reg1"}, decode_reg1, w[14:10]);
    checkOutput({name, "_reg2"}, decode_reg2, w[19:15]);
  endtask

  logic        outstanding;
  int          delay;
  logic [31:0] resp_addr;
  logic [31:0] exp_next;
  int          idle;
  logic        hold_prev;
  logic        snap_dv;
  logic [31:0] snap_pc;
  logic [31:0] snap_instr;
  logic        hung;
  logic        st, hl, rdr, g, rv;
  logic [31:0] rpc, rd, exp_word;

  initial begin
    // Cycle table: reset, first fetch, four stall cycles with a skid capture, release.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0000_1C15,  1'b0, 32'h100, 1'b0, 32'h0,   32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,          1'b1, 32'h104, 1'b1, 32'h100, 32'h0000_1C15};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h000A_5433,  1'b0, 32'h104, 1'b1, 32'h100, 32'h0000_1C15};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h104, 1'b1, 32'h100, 32'h0000_1C15};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'h104, 1'b1, 32'h100, 32'h0000_1C15};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h104, 1'b1, 32'h100, 32'h0000_1C15};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h108, 1'b1, 32'h104, 32'h000A_5433};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,          1'b1, 32'h108, 1'b0, 32'h104, 32'h000A_5433};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h108, 1'b0, 32'h104, 32'h000A_5433};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0013_2C9E,  1'b0, 32'h108, 1'b0, 32'h104, 32'h000A_5433};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h10C, 1'b1, 32'h108, 32'h0013_2C9E};

    reset = 1'b1;
    doReset();
    for (int i = 0; i < 13; i++) begin
      checkOutput($sformatf("tbl%0d_req", i), imem_req, vecs[i].exp_req);
      checkOutput($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].exp_addr);
      checkDecode($sformatf("tbl%0d", i), vecs[i].exp_dv, vecs[i].exp_pc, vecs[i].exp_instr);
      applyStimulus(vecs[i].stall, 0, 0, 32'd0, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      step();
    end

    // Redirect to an unaligned target while a response is outstanding.
    doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 1, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 0, 1, 32'h0000_0401); step();
    applyStimulus(1, 0, 0, 32'd0, 1, 0, 32'd0); step();
    checkOutput("redir_pre_dv", decode_valid, 1'b1);
    applyStimulus(0, 0, 1, 32'h0000_0203, 0, 0, 32'd0); step();
    checkOutput("redir_flush_dv", decode_valid, 1'b0);
    checkOutput("redir_drain_req", imem_req, 1'b0);
    applyStimulus(0, 0, 0, 32'd0, 0, 1, 32'hDEAD_BEEF); step();
    checkOutput("redir_req", imem_req, 1'b1);
    checkOutput("redir_addr", imem_addr, 32'h0000_0200);
    checkOutput("redir_stale_dv", decode_valid, 1'b0);
    applyStimulus(0, 0, 0, 32'd0, 1, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 0, 1, 32'h0000_0015); step();
    checkDecode("redir_target", 1'b1, 32'h0000_0200, 32'h0000_0015);

    // Redirect coinciding with the response in the same cycle.
    doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 1, 0, 32'd0); step();
    applyStimulus(0, 0, 1, 32'h0000_0300, 0, 1, 32'hBAD0_BAD0); step();
    checkOutput("same_dv", decode_valid, 1'b0);
    checkOutput("same_req", imem_req, 1'b1);
    checkOutput("same_addr", imem_addr, 32'h0000_0300);
    applyStimulus(0, 0, 0, 32'd0, 1, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 0, 1, 32'h0000_2C8A); step();
    checkDecode("same_target", 1'b1, 32'h0000_0300, 32'h0000_2C8A);

    // Halt while a response arrives: captured, outputs frozen, redirect ignored.
    doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 1, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 0, 1, 32'h0000_1111); step();
    applyStimulus(1, 0, 0, 32'd0, 1, 0, 32'd0); step();
    applyStimulus(0, 1, 0, 32'd0, 0, 1, 32'h0000_2222); step();
    checkDecode("halt_frozen", 1'b1, 32'h0000_0100, 32'h0000_1111);
    checkOutput("halt_req", imem_req, 1'b0);
    applyStimulus(0, 1, 1, 32'h0000_0500, 0, 0, 32'd0); step();
    checkDecode("halt_redir_ignored", 1'b1, 32'h0000_0100, 32'h0000_1111);
    checkOutput("halt_addr", imem_addr, 32'h0000_0104);
    applyStimulus(0, 0, 0, 32'd0, 0, 0, 32'd0); step();
    checkDecode("halt_release", 1'b1, 32'h0000_0104, 32'h0000_2222);
    checkOutput("halt_next_req", imem_req, 1'b1);
    checkOutput("halt_next_addr", imem_addr, 32'h0000_0108);

    // PC wrap from the top word back to zero.
    doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 0, 32'd0); step();
    applyStimulus(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 32'd0); step();
    checkOutput("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 32'd0, 1, 0, 32'd0); step();
    applyStimulus(0, 0, 0, 32'd0, 0, 1, 32'h0000_0001); step();
    checkDecode("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h0000_0001);
    checkOutput("wrap_req", imem_req, 1'b1);
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);

    // Randomized run: the retired instruction stream must be sequential from the
    // last redirect target, each word must match memory, and IF/ID must hold
    // still whenever decode is stalled or the core is halted.
    doReset();
    outstanding = 1'b0;
    delay       = 0;
    resp_addr   = 32'd0;
    exp_next    = 32'h0000_0100;
    idle        = 0;
    hold_prev   = 1'b0;
    hung        = 1'b0;
    snap_dv     = 1'b0;
    snap_pc     = 32'd0;
    snap_instr  = 32'd0;
    for (int cyc = 0; cyc < 3000 && !hung; cyc++) begin
      if (hold_prev) begin
        checkOutput("rand_hold_dv", decode_valid, snap_dv);
        checkOutput("rand_hold_pc", decode_pc, snap_pc);
        checkOutput("rand_hold_instr", decode_instr, snap_instr);
      end
      if (imem_req) checkOutput("rand_single_outstanding", outstanding, 1'b0);

      rv = 1'b0;
      rd = 32'd0;
      g  = 1'b0;
      if (outstanding) begin
        if (delay == 0) begin
          rv = 1'b1;
          rd = memWord(resp_addr);
          outstanding = 1'b0;
        end else begin
          delay--;
        end
      end else if (imem_req) begin
        g = ($urandom_range(0, 3) != 0);
        if (g) begin
          outstanding = 1'b1;
          resp_addr   = imem_addr;
          delay       = $urandom_range(0, 2);
        end
      end

      hl  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdr = !hl && ($urandom_range(0, 19) == 0);
      rpc = $urandom;

      if (rdr) begin
        exp_next = rpc & ~32'd3;
        idle = 0;
      end else if (decode_valid && !st && !hl) begin
        exp_word = memWord(exp_next);
        checkOutput("rand_pc", decode_pc, exp_next);
        checkOutput("rand_instr", decode_instr, exp_word);
        checkOutput("rand_opcode", decode_opcode, exp_word[4:0]);
        checkOutput("rand_reg1", decode_reg1, exp_word[14:10]);
        checkOutput("rand_reg2", decode_reg2, exp_word[19:15]);
        exp_next = exp_next + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end

      if (idle > 200) begin
        failures++;
        checks++;
        $display("[TB] FAIL rand_progress: no instruction retired for %0d cycles, required at most 200", idle);
        hung = 1'b1;
      end

      hold_prev  = (st || hl) && !rdr && decode_valid;
      snap_dv    = decode_valid;
      snap_pc    = decode_pc;
      snap_instr = decode_instr;
      applyStimulus(st, hl, rdr, rpc, g, rv, rd);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage and IF/ID pipeline register, directly upstream of the hazard unit and decode. Issues one outstanding instruction-memory request at a time and holds the fetched word stable while the hazard unit stalls or the core is halted. Extracts the opcode and source-register fields the hazard unit compares, and flushes and refetches on a branch or jump redirect from execute.

## Interface
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] must be 0
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; IF/ID register holds
- halted  in  1  core halted; all state frozen
- redirect_valid  in  1  execute resolved a taken branch or jump
- redirect_pc  in  32  target; bits [1:0] forced to 0
- imem_req  out  1  request valid, registered
- imem_addr  out  32  request word address, registered
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; at least 1 cycle after grant
- imem_rdata  in  32  response instruction
- decode_valid  out  1  IF/ID holds a real instruction
- decode_instr  out  32  IF/ID instruction
- decode_pc  out  32  IF/ID instruction address
- decode_opcode  out  5  decode_instr[4:0]
- decode_reg1  out  5  decode_instr[14:10]
- decode_reg2  out  5  decode_instr[19:15]

## Operation
- Reset: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, decode_valid=0, decode_instr=0, decode_pc=0, skid buffer empty. decode_opcode, decode_reg1 and decode_reg2 are combinational and therefore 0. Instruction 0 is an ADD to r0, which is harmless.
- IF/ID advance condition: adv = !stall && !halted.
- States:
  - IDLE: always go to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT.
  - WAIT: on imem_rvalid, load the word into IF/ID if adv or !decode_valid, then pc+=4 and go to REQ. Otherwise store it in the skid buffer and go to HOLD.
  - HOLD: imem_req=0. When adv, move the skid buffer into IF/ID, pc+=4, go to REQ.
  - DRAIN: discard the next imem_rvalid, then go to REQ.
- When adv and no new word is loaded that cycle, decode_valid<=0 (bubble).
- redirect_valid has priority over everything except halted and reset:
  - pc<=redirect_pc & ~3, decode_valid<=0, skid buffer cleared.
  - Next state: DRAIN if in WAIT, or if in REQ with imem_gnt asserted that cycle.
  - If WAIT has imem_rvalid asserted in the same cycle, that response is dropped and the next state is REQ.
  - Otherwise the next state is REQ. The next imem_addr is the redirect target.
- halted: freezes pc, state, imem_req, imem_addr and IF/ID.
  - A redirect during halted is ignored.
  - Exception: imem_rvalid in WAIT while halted is captured into the skid buffer and the state goes to HOLD, so the response is never lost.
  - imem_gnt while halted in REQ is still honoured and the state goes to WAIT.
- reset mid-request: return to reset state. An outstanding response arriving after reset is ignored because state is IDLE/REQ, not WAIT.
- pc arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- reset released at cycle 0 -> IDLE at cycle 0 -> imem_req=1 at cycle 1.
- gnt at cycle n, rvalid at n+1 -> decode_valid=1 at n+2 (registered), next imem_req at n+2.
- Peak throughput: 1 instruction per 2 cycles (single outstanding request).
- Redirect asserted at cycle n -> decode_valid=0 at n+1. imem_addr=target at n+1 if no drain is needed; otherwise one cycle after the drained response.
- decode_* outputs are stable for every cycle in which stall=1 or halted=1.

## Configuration
- FETCH_PERF_COUNT_EN defined adds two ports and their 32-bit counters:
  - fetch_count  out  32: increments on each word loaded into IF/ID.
  - stall_count  out  32: increments each cycle decode_valid && stall && !halted.
  - Both counters reset to 0 and wrap.
- Without the macro, neither the ports nor the counters exist.

## Test plan
- Reset with RESET_PC=32'h100, imem gnt immediate and rvalid +1 returning 32'h0000_1C15 -> imem_req at cycle 1 with addr 32'h100; decode_valid at cycle 3 with decode_pc=32'h100, opcode=21 (LW), reg1=7.
- stall held 4 cycles while decode_valid=1 -> decode_instr/pc unchanged; the next response goes to the skid buffer in HOLD with no new imem_req; on stall release, IF/ID takes the buffered word at pc+4.
- redirect_valid with redirect_pc=32'h203 while in WAIT -> decode_valid=0 next cycle; the following rvalid is discarded; imem_addr=32'h200.
- redirect and imem_rvalid in the same WAIT cycle -> the response is dropped and the next request goes to the target.
- halted asserted during WAIT with rvalid arriving -> word captured, all outputs frozen; after halted drops, the word appears in IF/ID.
- pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0.
